// File: rtl/spi_dac_pkg.sv
// Shared types and constants for the serial DAC transmitter (spi_dac_tx).
// Holds the FSM state encoding, the fixed frame length and the DAC power-down mode codes.
package spi_dac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int FRAME_BITS = 16;

    localparam logic [1:0] MODE_NORMAL  = 2'b00;
    localparam logic [1:0] MODE_PD_1K   = 2'b01;
    localparam logic [1:0] MODE_PD_100K = 2'b10;
    localparam logic [1:0] MODE_PD_HIZ  = 2'b11;

endpackage

// File: rtl/spi_dac_sclk_gen.sv
// SCLK divider for spi_dac_tx: registered SCLK (high first half, low second half of each bit)
// plus fall_tick (SCLK falls next edge) and bit_end (last cycle of a bit) strobes.
module spi_dac_sclk_gen #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    output logic sclk,
    output logic fall_tick,
    output logic bit_end
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter parks at zero whenever the frame is not shifting, so each frame starts on a fresh bit.
    always_comb begin
        cnt_d = '0;
        if (run && cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            sclk  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            sclk  <= (cnt_d < HALF);
        end
    end

    assign fall_tick = run && (cnt_q == HALF - 1'b1);
    assign bit_end   = run && (cnt_q == LAST);

endmodule

// File: rtl/spi_dac_tx.sv
// 3-wire (SYNC_N/SCLK/DIN) transmitter for DAC121S101-class DACs; 16-bit frames, MSB first.
// Optional macro SPI_DAC_TX_REPEAT_EN: retransmit the last frame when no new sample is offered.
module spi_dac_tx
    import spi_dac_pkg::*;
#(
    parameter int CLK_DIV = 10,
    parameter int DATA_W  = 12,
    parameter int GAP_CYC = CLK_DIV
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic [1:0]        i_mode,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_sync_n,
    output logic              o_sclk,
    output logic              o_din,
    output logic [1:0]        dbg_state
);

    // Handshake: a sample is taken on a clk edge where i_valid && o_ready; i_valid while
    // o_ready is low is ignored, and the source need not hold anything stable.

    localparam int RAW_W = 4 + DATA_W;
    localparam int GW    = $clog2(GAP_CYC + 1);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);
`ifdef SPI_DAC_TX_REPEAT_EN
    // One extra gap cycle stands in for the IDLE cycle, keeping the frame rate identical.
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC);
`else
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
`endif

    state_t                state_q, state_d;
    logic [FRAME_BITS-2:0] sr_q;
    logic [3:0]            bit_cnt_q;
    logic [GW-1:0]         gap_cnt_q;
    logic                  gap_last;
    logic                  accept;
    logic                  bit_end;
    logic                  fall_tick;
    logic [RAW_W-1:0]      raw_word;
    logic [FRAME_BITS-1:0] new_word;
`ifdef SPI_DAC_TX_REPEAT_EN
    logic                  reload;
    logic [FRAME_BITS-1:0] word_q;
`endif

    assign raw_word = {2'b00, i_mode, i_data};
    generate
        if (RAW_W >= FRAME_BITS) begin : g_trunc
            assign new_word = raw_word[RAW_W-1 -: FRAME_BITS];
        end else begin : g_pad
            assign new_word = {raw_word, {(FRAME_BITS - RAW_W){1'b0}}};
        end
    endgenerate

    spi_dac_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk       (clk),
        .resetn    (resetn),
        .run       (state_q == SHIFT),
        .sclk      (o_sclk),
        .fall_tick (fall_tick),
        .bit_end   (bit_end)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        gap_last = (state_q == GAP) && (gap_cnt_q == GAP_LAST);
        o_ready  = (state_q == IDLE);
`ifdef SPI_DAC_TX_REPEAT_EN
        reload   = 1'b0;
        if (gap_last) o_ready = 1'b1;
`endif
        accept   = i_valid && o_ready;
        case (state_q)
            IDLE:  if (accept) state_d = SHIFT;
            SHIFT: if (bit_end && bit_cnt_q == LAST_BIT) state_d = GAP;
            GAP: begin
                if (gap_last) begin
`ifdef SPI_DAC_TX_REPEAT_EN
                    state_d = SHIFT;
                    reload  = !i_valid;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            o_sync_n  <= 1'b1;
            o_din     <= 1'b0;
`ifdef SPI_DAC_TX_REPEAT_EN
            word_q    <= '0;
`endif
        end else begin
            if (accept) begin
                sr_q      <= new_word[FRAME_BITS-2:0];
                o_din     <= new_word[FRAME_BITS-1];
                o_sync_n  <= 1'b0;
                bit_cnt_q <= '0;
                gap_cnt_q <= '0;
`ifdef SPI_DAC_TX_REPEAT_EN
                word_q    <= new_word;
            end else if (reload) begin
                sr_q      <= word_q[FRAME_BITS-2:0];
                o_din     <= word_q[FRAME_BITS-1];
                o_sync_n  <= 1'b0;
                bit_cnt_q <= '0;
                gap_cnt_q <= '0;
`endif
            end else if (state_q == SHIFT && bit_end) begin
                // The 4-bit counter wraps back to zero on the final bit.
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    o_sync_n <= 1'b1;
                    o_din    <= 1'b0;
                end else begin
                    o_din <= sr_q[FRAME_BITS-2];
                    sr_q  <= {sr_q[FRAME_BITS-3:0], 1'b0};
                end
            end else if (state_q == GAP) begin
                gap_cnt_q <= gap_last ? '0 : gap_cnt_q + 1'b1;
            end
        end
    end

    // SCLK only falls while a frame is framed by SYNC_N.
    always_ff @(posedge clk) begin
        if (resetn && fall_tick) begin
            a_fall_in_frame: assert (!o_sync_n);
        end
    end

    assign o_busy    = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_dac_tx.sv
// Bench for spi_dac_tx: random samples checked against a frame-level model of the DAC link.
// Build with SPI_DAC_TX_REPEAT_EN defined to exercise the repeat path.
module tb_spi_dac_tx;
    import spi_dac_pkg::*;

    localparam int CLK_DIV   = 10;
    localparam int DATA_W    = 12;
    localparam int GAP_CYC   = 10;
    localparam int FRAME_LEN = 16 * CLK_DIV;
    localparam int PERIOD    = FRAME_LEN + GAP_CYC + 1;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              i_valid = 1'b0;
    logic [DATA_W-1:0] i_data = '0;
    logic [1:0]        i_mode = '0;
    logic              o_ready, o_busy, o_sync_n, o_sclk, o_din;
    logic [1:0]        dbg_state;

    spi_dac_tx #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .GAP_CYC(GAP_CYC)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .i_mode    (i_mode),
        .o_ready   (o_ready),
        .o_busy    (o_busy),
        .o_sync_n  (o_sync_n),
        .o_sclk    (o_sclk),
        .o_din     (o_din),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // line monitor: decodes frames from the pins, sampled on the falling clk edge
    logic        prev_sync = 1'b1, prev_sclk = 1'b1, prev_din = 1'b0;
    bit          in_frame = 0;
    logic [15:0] shreg;
    int          nbits, start_cyc, gap_run = 0, glitch_errs = 0;
    logic [15:0] mon_word_q[$];
    int          mon_start_q[$], mon_len_q[$], mon_nbits_q[$], gap_q[$];
    logic [15:0] exp_q[$];

    always @(negedge clk) begin
        if (!resetn) begin
            in_frame = 0; gap_run = 0;
            prev_sync = 1'b1; prev_sclk = 1'b1; prev_din = 1'b0;
        end else begin
            if (prev_sync && !o_sync_n) begin
                if (gap_run > 0) gap_q.push_back(gap_run);
                gap_run = 0; in_frame = 1; start_cyc = cyc; nbits = 0; shreg = '0;
            end
            if (in_frame && !o_sync_n && prev_sclk && !o_sclk) begin
                shreg = {shreg[14:0], o_din};
                nbits++;
            end
            if (!prev_sync && !o_sync_n && (o_din !== prev_din) && !(!prev_sclk && o_sclk))
                glitch_errs++;
            if (!prev_sync && o_sync_n && in_frame) begin
                mon_word_q.push_back(shreg);
                mon_start_q.push_back(start_cyc);
                mon_len_q.push_back(cyc - start_cyc);
                mon_nbits_q.push_back(nbits);
                in_frame = 0; gap_run = 0;
            end
            if (o_sync_n && o_busy) gap_run++;
            else if (!o_busy && gap_run > 0) begin
                gap_q.push_back(gap_run);
                gap_run = 0;
            end
            prev_sync = o_sync_n; prev_sclk = o_sclk; prev_din = o_din;
        end
    end

    // reference model: frame word = {2'b00, mode, data}
    function automatic logic [15:0] frame_of(input int d, input int m);
        return 16'((m << 12) + d);
    endfunction

    task automatic clear_queues();
        mon_word_q.delete(); mon_start_q.delete(); mon_len_q.delete();
        mon_nbits_q.delete(); gap_q.delete(); exp_q.delete();
    endtask

    // driver: offer a sample until it is taken; acc0 is the cycle index whose closing edge accepted it
    task automatic offer(input int d, input int m, input bit hold, output int acc0, output bit ok);
        ok = 0; acc0 = -1;
        i_data = DATA_W'(d); i_mode = 2'(m);
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            i_valid = 1'b1;
            if (o_ready) begin
                @(posedge clk); #1;
                acc0 = cyc - 1; ok = 1;
                if (!hold) i_valid = 1'b0;
                break;
            end
        end
        if (!ok) i_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (o_ready && !o_busy) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; i_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (o_sync_n !== 1'b1) begin bad++; $display("FAIL reset_sync_n got=%b want=1", o_sync_n); end
        total++; if (o_sclk !== 1'b1) begin bad++; $display("FAIL reset_sclk got=%b want=1", o_sclk); end
        total++; if (o_din !== 1'b0) begin bad++; $display("FAIL reset_din got=%b want=0", o_din); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", o_ready); end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int acc0, rdy;
        bit ok;
        clear_queues();
        offer(12'hA5C, 0, 0, acc0, ok);
        exp_q.push_back(frame_of(12'hA5C, 0));
        total++; if (!ok) begin bad++; $display("FAIL single_accept got=timeout want=accept"); end
        rdy = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (o_ready) begin rdy = cyc; break; end
        end
        total++; if (rdy - acc0 != PERIOD) begin bad++; $display("FAIL single_ready_cycle got=%0d want=%0d", rdy - acc0, PERIOD); end
        total++;
        if (mon_word_q.size() != 1) begin bad++; $display("FAIL single_frames got=%0d want=1", mon_word_q.size()); end
        else begin
            logic [15:0] w, e;
            w = mon_word_q.pop_front(); e = exp_q.pop_front();
            total++; if (w !== e) begin bad++; $display("FAIL single_word got=%h want=%h", w, e); end
            total++; if (mon_len_q[0] != FRAME_LEN) begin bad++; $display("FAIL single_sync_low got=%0d want=%0d", mon_len_q[0], FRAME_LEN); end
            total++; if (mon_nbits_q[0] != 16) begin bad++; $display("FAIL single_nbits got=%0d want=16", mon_nbits_q[0]); end
            total++; if (mon_start_q[0] - acc0 != 1) begin bad++; $display("FAIL single_start got=%0d want=1", mon_start_q[0] - acc0); end
        end
    endtask

    task automatic test_back_to_back();
        int a1, a2;
        bit ok1, ok2, ok3;
        clear_queues();
        offer(12'h000, 0, 1, a1, ok1);
        offer(12'hFFF, 0, 0, a2, ok2);
        wait_idle(ok3);
        total++; if (!(ok1 && ok2 && ok3)) begin bad++; $display("FAIL b2b_handshake got=%0b%0b%0b want=111", ok1, ok2, ok3); end
        total++; if (a2 - a1 != PERIOD) begin bad++; $display("FAIL b2b_accept_spacing got=%0d want=%0d", a2 - a1, PERIOD); end
        total++;
        if (mon_word_q.size() != 2) begin bad++; $display("FAIL b2b_frames got=%0d want=2", mon_word_q.size()); end
        else begin
            total++; if (mon_word_q[0] !== 16'h0000) begin bad++; $display("FAIL b2b_word0 got=%h want=0000", mon_word_q[0]); end
            total++; if (mon_word_q[1] !== 16'h0FFF) begin bad++; $display("FAIL b2b_word1 got=%h want=0fff", mon_word_q[1]); end
            total++; if (mon_start_q[1] - mon_start_q[0] != PERIOD) begin bad++; $display("FAIL b2b_frame_spacing got=%0d want=%0d", mon_start_q[1] - mon_start_q[0], PERIOD); end
            total++; if (gap_q.size() < 1 || gap_q[0] != GAP_CYC) begin bad++; $display("FAIL b2b_gap got=%0d want=%0d", (gap_q.size() > 0) ? gap_q[0] : -1, GAP_CYC); end
        end
    endtask

    task automatic test_mode_random();
        int acc0, d, m;
        bit ok, okw;
        clear_queues();
        offer(12'h001, MODE_PD_HIZ, 0, acc0, ok);
        exp_q.push_back(16'h3001);
        for (int k = 0; k < 5; k++) begin
            d = $urandom_range(0, 4095);
            m = $urandom_range(0, 3);
            offer(d, m, 0, acc0, okw);
            ok = ok && okw;
            exp_q.push_back(frame_of(d, m));
        end
        wait_idle(okw);
        total++; if (!(ok && okw)) begin bad++; $display("FAIL mode_handshake got=timeout want=accept"); end
        total++;
        if (mon_word_q.size() != exp_q.size()) begin bad++; $display("FAIL mode_frames got=%0d want=%0d", mon_word_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && mon_word_q.size() > 0) begin
            logic [15:0] w, e;
            w = mon_word_q.pop_front(); e = exp_q.pop_front();
            total++; if (w !== e) begin bad++; $display("FAIL mode_word got=%h want=%h", w, e); end
        end
    endtask

    task automatic test_reset_mid();
        int acc0, d;
        bit ok, okw;
        clear_queues();
        offer($urandom_range(0, 4095), $urandom_range(0, 3), 0, acc0, ok);
        while (cyc < acc0 + 77) @(negedge clk);
        total++; if (!(o_sync_n === 1'b0 && o_sclk === 1'b0)) begin bad++; $display("FAIL midrst_pre got=%b%b want=00", o_sync_n, o_sclk); end
        #2 resetn = 1'b0;
        #1;
        total++; if (o_sync_n !== 1'b1) begin bad++; $display("FAIL midrst_sync_n got=%b want=1", o_sync_n); end
        total++; if (o_sclk !== 1'b1) begin bad++; $display("FAIL midrst_sclk got=%b want=1", o_sclk); end
        total++; if (o_din !== 1'b0) begin bad++; $display("FAIL midrst_din got=%b want=0", o_din); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", o_ready); end
        clear_queues();
        d = $urandom_range(0, 4095);
        offer(d, MODE_PD_1K, 0, acc0, okw);
        exp_q.push_back(frame_of(d, MODE_PD_1K));
        wait_idle(ok);
        total++;
        if (mon_word_q.size() != 1 || !okw || !ok) begin bad++; $display("FAIL midrst_frames got=%0d want=1", mon_word_q.size()); end
        else begin
            total++; if (mon_word_q[0] !== exp_q[0]) begin bad++; $display("FAIL midrst_word got=%h want=%h", mon_word_q[0], exp_q[0]); end
            total++; if (mon_len_q[0] != FRAME_LEN) begin bad++; $display("FAIL midrst_len got=%0d want=%0d", mon_len_q[0], FRAME_LEN); end
        end
    endtask

    task automatic test_ignore_busy();
        int acc0, d;
        bit ok, okw;
        clear_queues();
        d = $urandom_range(0, 4095);
        offer(d, MODE_PD_100K, 0, acc0, ok);
        exp_q.push_back(frame_of(d, MODE_PD_100K));
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(5, 25)) @(negedge clk);
            if (o_busy) begin
                i_valid = 1'b1; i_data = DATA_W'($urandom_range(0, 4095)); i_mode = 2'($urandom_range(0, 3));
                @(negedge clk);
                i_valid = 1'b0;
            end
        end
        wait_idle(okw);
        repeat (200) @(negedge clk);
        total++;
        if (mon_word_q.size() != 1 || !ok || !okw) begin bad++; $display("FAIL ignore_frames got=%0d want=1", mon_word_q.size()); end
        else begin
            total++; if (mon_word_q[0] !== exp_q[0]) begin bad++; $display("FAIL ignore_word got=%h want=%h", mon_word_q[0], exp_q[0]); end
        end
    endtask

`ifdef SPI_DAC_TX_REPEAT_EN
    task automatic test_repeat();
        int acc0, a2;
        bit ok, ok2;
        clear_queues();
        offer(12'h123, 0, 0, acc0, ok);
        for (int n = 0; n < 800 && mon_word_q.size() < 3; n++) @(negedge clk);
        total++;
        if (mon_word_q.size() < 3 || !ok) begin bad++; $display("FAIL repeat_frames got=%0d want=3", mon_word_q.size()); end
        else begin
            total++; if (mon_start_q[0] - acc0 != 1) begin bad++; $display("FAIL repeat_start got=%0d want=1", mon_start_q[0] - acc0); end
            for (int k = 0; k < 3; k++) begin
                total++; if (mon_word_q[k] !== 16'h0123) begin bad++; $display("FAIL repeat_word%0d got=%h want=0123", k, mon_word_q[k]); end
            end
            for (int k = 1; k < 3; k++) begin
                total++; if (mon_start_q[k] - mon_start_q[k-1] != PERIOD) begin bad++; $display("FAIL repeat_period%0d got=%0d want=%0d", k, mon_start_q[k] - mon_start_q[k-1], PERIOD); end
            end
        end
        for (int n = 0; n < 400 && dbg_state != GAP; n++) @(negedge clk);
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL repeat_gap_ready got=%b want=0", o_ready); end
        clear_queues();
        offer(12'h456, 0, 0, a2, ok2);
        for (int n = 0; n < 800 && mon_word_q.size() < 2; n++) @(negedge clk);
        total++;
        if (mon_word_q.size() < 2 || !ok2) begin bad++; $display("FAIL repeat_new_frames got=%0d want=2", mon_word_q.size()); end
        else begin
            total++; if (mon_word_q[0] !== 16'h0456) begin bad++; $display("FAIL repeat_new_word got=%h want=0456", mon_word_q[0]); end
            total++; if (mon_start_q[0] - a2 != 1) begin bad++; $display("FAIL repeat_new_start got=%0d want=1", mon_start_q[0] - a2); end
            total++; if (mon_word_q[1] !== 16'h0456) begin bad++; $display("FAIL repeat_new_again got=%h want=0456", mon_word_q[1]); end
        end
    endtask
`endif

    task automatic test_glitch_free();
        total++; if (glitch_errs != 0) begin bad++; $display("FAIL din_stability got=%0d want=0", glitch_errs); end
    endtask

    initial begin
        test_reset();
`ifdef SPI_DAC_TX_REPEAT_EN
        test_repeat();
`else
        test_single();
        test_back_to_back();
        test_mode_random();
        test_reset_mid();
        test_ignore_busy();
`endif
        test_glitch_free();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
